// File: rtl/nios2_mult_pipe_pkg.sv
// Shared types and helpers for the Nios II multiplier pipeline.
// The optional high-word support is enabled by the NIOS2_MULT_HI_EN macro.
package nios2_mult_pkg;

  // Product word select and operand signedness, encoded as the in_mode field.
  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULXSS = 2'b01,
    MULXSU = 2'b10,
    MULXUU = 2'b11
  } mult_mode_e;

  // Number of SLICE_W-wide slices per operand.
  function automatic int unsigned num_slices(input int unsigned data_w,
                                             input int unsigned slice_w);
    return data_w / slice_w;
  endfunction

  // Operand A is sign-extended for MULXSS and MULXSU.
  function automatic logic mode_a_signed(input mult_mode_e mode);
    return (mode == MULXSS) || (mode == MULXSU);
  endfunction

  // Operand B is sign-extended only for MULXSS.
  function automatic logic mode_b_signed(input mult_mode_e mode);
    return (mode == MULXSS);
  endfunction

  // Every mode except MUL_LO returns the upper product word.
  function automatic logic mode_hi_word(input mult_mode_e mode);
    return (mode != MUL_LO);
  endfunction

endpackage

// File: rtl/nios2_mult_pipe_if.sv
// Request/response bundle of the multiplier pipeline.
// master: the A-stage/writeback side; slave: the pipeline itself.
interface nios2_mult_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_src1, in_src2, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/nios2_mult_slice.sv
// Registered (SLICE_W+1)x(SLICE_W+1) signed slice multiplier with enable.
module nios2_mult_slice
  import nios2_mult_pkg::*;
#(
  parameter int unsigned SLICE_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic signed [SLICE_W:0]     a_i,
  input  logic signed [SLICE_W:0]     b_i,
  output logic signed [2*SLICE_W+1:0] p_o
);

  logic signed [2*SLICE_W+1:0] p_q;

  // Partial product register, updated only when the pipeline advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= a_i * b_i;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/nios2_mult_pipe.sv
// Two-stage handshaked multiplier: S1 registers slice partial products,
// S2 registers the summed product; one global enable stalls both stages.
// Define NIOS2_MULT_HI_EN for signed/mixed modes and high-word results;
// otherwise only low-word partial products exist and in_mode is ignored.
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned TAG_W   = 5
) (
  input logic              clk,
  input logic              reset_n,
  input logic              flush,
  nios2_mult_pipe_if.slave bus
);

  localparam int unsigned NumSlices = num_slices(DATA_W, SLICE_W);
  localparam int unsigned PpW       = 2 * SLICE_W + 2;
`ifdef NIOS2_MULT_HI_EN
  localparam bit          HiEn      = 1'b1;
  localparam int unsigned ProdW     = 2 * DATA_W;
`else
  localparam bit          HiEn      = 1'b0;
  localparam int unsigned ProdW     = DATA_W;
`endif

  logic advance;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [ProdW-1:0] prod_sum, s2_prod_q;
  logic [ProdW-1:0] term;
  logic ext_a, ext_b;

  logic signed [SLICE_W:0] a_sl [NumSlices];
  logic signed [SLICE_W:0] b_sl [NumSlices];
  logic signed [PpW-1:0]   s1_pp [NumSlices][NumSlices];

  assign advance      = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

`ifdef NIOS2_MULT_HI_EN
  logic hi_sel, s1_hi_q, s2_hi_q;
  assign ext_a  = mode_a_signed(mult_mode_e'(bus.in_mode)) & bus.in_src1[DATA_W-1];
  assign ext_b  = mode_b_signed(mult_mode_e'(bus.in_mode)) & bus.in_src2[DATA_W-1];
  assign hi_sel = mode_hi_word(mult_mode_e'(bus.in_mode));
`else
  logic unused_mode;
  assign ext_a       = 1'b0;
  assign ext_b       = 1'b0;
  assign unused_mode = ^bus.in_mode;
`endif

  // Only the top slice carries the extension bit; lower slices are non-negative.
  for (genvar g = 0; g < NumSlices; g++) begin : g_split
    if (g == NumSlices - 1) begin : g_top
      assign a_sl[g] = {ext_a, bus.in_src1[g*SLICE_W +: SLICE_W]};
      assign b_sl[g] = {ext_b, bus.in_src2[g*SLICE_W +: SLICE_W]};
    end else begin : g_low
      assign a_sl[g] = {1'b0, bus.in_src1[g*SLICE_W +: SLICE_W]};
      assign b_sl[g] = {1'b0, bus.in_src2[g*SLICE_W +: SLICE_W]};
    end
  end

  // Pairs landing wholly above the low word are only built with high-word support.
  for (genvar gi = 0; gi < NumSlices; gi++) begin : g_row
    for (genvar gj = 0; gj < NumSlices; gj++) begin : g_col
      if (HiEn || (gi + gj < NumSlices)) begin : g_mul
        nios2_mult_slice #(
          .SLICE_W (SLICE_W)
        ) u_slice (
          .clk_i  (clk),
          .rst_ni (reset_n),
          .en_i   (advance),
          .a_i    (a_sl[gi]),
          .b_i    (b_sl[gj]),
          .p_o    (s1_pp[gi][gj])
        );
      end else begin : g_none
        assign s1_pp[gi][gj] = '0;
      end
    end
  end

  // Sum of shifted, sign-extended partial products, modulo 2^ProdW.
  always_comb begin
    prod_sum = '0;
    term     = '0;
    for (int unsigned i = 0; i < NumSlices; i++) begin
      for (int unsigned j = 0; j < NumSlices; j++) begin
        term     = ProdW'(s1_pp[i][j]);
        prod_sum = prod_sum + (term << ((i + j) * SLICE_W));
      end
    end
  end

  // Stage valids: flush wins over stall, otherwise shift on advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (advance) begin
      s1_valid_d = bus.in_valid;
      s2_valid_d = s1_valid_q;
    end
  end

  // Stage valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // S1 sideband registers; data keeps its value across flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_tag_q <= '0;
    end else if (advance) begin
      s1_tag_q <= bus.in_tag;
    end
  end

  // S2 product and sideband registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_prod_q <= '0;
      s2_tag_q  <= '0;
    end else if (advance) begin
      s2_prod_q <= prod_sum;
      s2_tag_q  <= s1_tag_q;
    end
  end

`ifdef NIOS2_MULT_HI_EN
  // Word select travels alongside the data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hi_q <= 1'b0;
      s2_hi_q <= 1'b0;
    end else if (advance) begin
      s1_hi_q <= hi_sel;
      s2_hi_q <= s1_hi_q;
    end
  end

  assign bus.out_result = s2_hi_q ? s2_prod_q[2*DATA_W-1:DATA_W] : s2_prod_q[DATA_W-1:0];
`else
  assign bus.out_result = s2_prod_q;
`endif

  assign bus.out_valid = s2_valid_q;
  assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Directed bench for nios2_mult_pipe; expectations follow NIOS2_MULT_HI_EN.
module tb_nios2_mult_pipe;

`ifdef NIOS2_MULT_HI_EN
  localparam logic [31:0] ExpSs   = 32'h0000_0000;
  localparam logic [31:0] ExpSu   = 32'hFFFF_FFFF;
  localparam logic [31:0] ExpUu   = 32'hFFFF_FFFE;
  localparam logic [31:0] ExpNeg  = 32'hFFFF_FFFF;
  localparam logic [31:0] ExpHi16 = 32'h0000_0001;
`else
  localparam logic [31:0] ExpSs   = 32'h0000_0001;
  localparam logic [31:0] ExpSu   = 32'h0000_0001;
  localparam logic [31:0] ExpUu   = 32'h0000_0001;
  localparam logic [31:0] ExpNeg  = 32'hFFFF_FFFA;
  localparam logic [31:0] ExpHi16 = 32'h0000_0000;
`endif

  logic clk;
  logic reset_n;
  logic flush;
  int   vectors;
  int   miscompares;

  nios2_mult_pipe_if #(.DATA_W(32), .TAG_W(5)) bus ();

  nios2_mult_pipe #(
    .DATA_W  (32),
    .SLICE_W (16),
    .TAG_W   (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated request; checks acceptance, 2-edge latency, result and tag.
  task automatic single(input string name, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    #1 check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_result"}, bus.out_result, exp);
    check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
  endtask

  initial begin
    int          tx;
    int          rx;
    logic        held;
    logic [31:0] held_res;
    logic [4:0]  held_tag;

    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_mode   = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    reset_n = 1'b1;
    #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Mode coverage on all-ones operands.
    single("mul_lo_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001);
    single("mulxss_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, ExpSs);
    single("mulxsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, ExpSu);
    single("mulxuu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, ExpUu);
    single("mulxuu_hi16", 2'b11, 32'h0001_0000, 32'h0001_0000, 5'd7, ExpHi16);
    single("mulxss_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd8, ExpNeg);
    single("mul_lo_small", 2'b00, 32'd7, 32'd6, 5'd9, 32'd42);
    single("mul_lo_wrap", 2'b00, 32'h8000_0000, 32'd2, 5'd10, 32'd0);

    // Eight back-to-back requests with a three-cycle consumer stall.
    tx   = 0;
    rx   = 0;
    held = 1'b0;
    held_res = '0;
    held_tag = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      @(negedge clk);
      if (held) begin
        check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold_result", bus.out_result, held_res);
        check("stall_hold_tag", 32'(bus.out_tag), 32'(held_tag));
      end
      bus.out_ready = !(c >= 4 && c < 7);
      bus.in_valid  = (tx < 8);
      bus.in_src1   = 32'(tx + 1);
      bus.in_src2   = 32'h1000_0001;
      bus.in_mode   = 2'b00;
      bus.in_tag    = 5'(tx);
      #1;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          check("stream_result", bus.out_result, 32'(rx + 1) * 32'h1000_0001);
          check("stream_tag", 32'(bus.out_tag), 32'(rx));
          rx++;
          held = 1'b0;
        end else begin
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
          held     = 1'b1;
          held_res = bus.out_result;
          held_tag = bus.out_tag;
        end
      end
      if (bus.in_valid && bus.in_ready) tx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_rx_count", 32'(rx), 32'd8);
    check("stream_tx_count", 32'(tx), 32'd8);
    @(negedge clk);
    check("stream_no_dup", 32'(bus.out_valid), 32'd0);

    // Flush with S1 and S2 occupied plus a request in the same cycle.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_src1   = 32'd5;
    bus.in_src2   = 32'd5;
    bus.in_tag    = 5'd11;
    @(posedge clk);
    @(negedge clk);
    bus.in_src1 = 32'd6;
    bus.in_tag  = 5'd12;
    @(posedge clk);
    @(negedge clk);
    check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.in_src1 = 32'd7;
    bus.in_tag  = 5'd13;
    flush       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_valid_0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("flush_valid_1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("flush_valid_2", 32'(bus.out_valid), 32'd0);
    single("post_flush", 2'b00, 32'd9, 32'd9, 5'd14, 32'd81);

    // Asynchronous reset with two requests in flight.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_src1  = 32'h0000_1234;
    bus.in_src2  = 32'h0000_0010;
    bus.in_mode  = 2'b00;
    bus.in_tag   = 5'd21;
    @(posedge clk);
    @(negedge clk);
    bus.in_tag = 5'd22;
    @(posedge clk);
    @(negedge clk);
    #1 check("rstmid_pre_valid", 32'(bus.out_valid), 32'd1);
    check("rstmid_pre_result", bus.out_result, 32'h0001_2340);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rstmid_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_result", bus.out_result, 32'd0);
    check("rstmid_tag", 32'(bus.out_tag), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("rstmid_drop_0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("rstmid_drop_1", 32'(bus.out_valid), 32'd0);
    single("post_reset", 2'b00, 32'h0001_0001, 32'h0001_0001, 5'd23, 32'h0002_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
